flow_csr_axil_slave: RTL and testbench

- AXI4-Lite slave CSR responder for the flow-classification datapath.
- Exposes the 104-bit flow key from the flow key generator as coherent read-only 32-bit words.
- Provides an auto-incrementing write window into the flow-table hash BRAM.
- Sits between the PS AXI-Lite interconnect (GP master) and the flow_key_gen / flow_table blocks.

---
 rtl/flow_csr_axil_slave_if.sv | 31 +++
 rtl/flow_csr_axil_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_flow_csr_axil_slave.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_csr_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS GP interconnect and the flow CSR responder.
// The master modport is the interconnect side; the slave modport is the CSR block side.
interface flow_csr_axil_slave_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/flow_csr_axil_slave.sv
// AXI4-Lite CSR responder: coherent read-out of the 104-bit flow key through a
// shadow register, plus an auto-incrementing write window into the hash BRAM.
module flow_csr_axil_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000A000,
  parameter int          BRAM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  flow_csr_axil_slave_if.slave   s_axil,
  input  logic [103:0]           flow_key,
  output logic                   bram_we,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [31:0]            bram_wdata
);

  localparam logic [7:0] OFF_KEY32  = 8'h00;
  localparam logic [7:0] OFF_KEY64  = 8'h04;
  localparam logic [7:0] OFF_KEY96  = 8'h08;
  localparam logic [7:0] OFF_BRAM   = 8'h0C;
  localparam logic [7:0] OFF_KEY128 = 8'h10;
  localparam logic [7:0] OFF_PTR    = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_e;

  wr_state_e              wr_state_q, wr_state_d;
  rd_state_e              rd_state_q, rd_state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic [31:0]            awaddr_q, awaddr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  // Key word 0 is returned live on the capturing read, so only bits [103:32] are kept.
  logic [71:0]            shadow_q, shadow_d;
  logic [BRAM_ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;
  logic                   wrap_q, wrap_d;
  logic                   bram_we_q, bram_we_d;
  logic [BRAM_ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [31:0]            bram_wdata_q, bram_wdata_d;

  logic aw_hs, w_hs, ar_hs, wr_go;

  assign aw_hs = s_axil.awvalid && awready_q;
  assign w_hs  = s_axil.wvalid  && wready_q;
  assign ar_hs = s_axil.arvalid && arready_q;

  // Write channel: collect AW and W in any order, then apply the register effect.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    wr_state_d   = wr_state_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    ptr_d        = ptr_q;
    wr_cnt_d     = wr_cnt_q;
    wrap_d       = wrap_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    wr_go        = 1'b0;

    if (aw_hs) awaddr_d = s_axil.awaddr;
    if (w_hs) begin
      wdata_d = s_axil.wdata;
      wstrb_d = s_axil.wstrb;
    end

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_go = 1'b1;
        else if (aw_hs)    wr_state_d = WR_HAVE_ADDR;
        else if (w_hs)     wr_state_d = WR_HAVE_DATA;
      end
      WR_HAVE_ADDR: if (w_hs)  wr_go = 1'b1;
      WR_HAVE_DATA: if (aw_hs) wr_go = 1'b1;
      WR_RESP: begin
        if (s_axil.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // awaddr_d/wdata_d/wstrb_d already hold the merged latched-or-incoming halves here.
    if (wr_go) begin
      wr_state_d = WR_RESP;
      bvalid_d   = 1'b1;
      if (awaddr_d[31:8] != BASE_ADDR[31:8]) begin
        bresp_d = RESP_DECERR;
      end else begin
        case (awaddr_d[7:0])
          OFF_KEY32, OFF_KEY64, OFF_KEY96, OFF_KEY128, OFF_STATUS: bresp_d = RESP_SLVERR;
          OFF_BRAM: begin
            if (wstrb_d == 4'hF) begin
              bresp_d      = RESP_OKAY;
              bram_we_d    = 1'b1;
              bram_addr_d  = ptr_q;
              bram_wdata_d = wdata_d;
              ptr_d        = ptr_q + BRAM_ADDR_W'(1);
              if (&ptr_q) wrap_d = 1'b1;
              if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
              bresp_d = RESP_SLVERR;
            end
          end
          OFF_PTR: begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < BRAM_ADDR_W; i++) begin
              if (wstrb_d[i/8]) ptr_d[i] = wdata_d[i];
            end
          end
          default: bresp_d = RESP_DECERR;
        endcase
      end
    end

    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_DATA);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_ADDR);
  end

  // Read channel: registered data one cycle after the AR handshake; sees pre-write CSR values.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    shadow_d   = shadow_q;

    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          rdata_d    = 32'h0;
          rresp_d    = RESP_OKAY;
          if (s_axil.araddr[31:8] != BASE_ADDR[31:8]) begin
            rresp_d = RESP_DECERR;
          end else begin
            case (s_axil.araddr[7:0])
              OFF_KEY32: begin
                rdata_d  = flow_key[31:0];
                shadow_d = flow_key[103:32];
              end
              OFF_KEY64:  rdata_d = shadow_q[31:0];
              OFF_KEY96:  rdata_d = shadow_q[63:32];
              OFF_BRAM:   rdata_d = 32'h0;
              OFF_KEY128: rdata_d = {24'h0, shadow_q[71:64]};
              OFF_PTR:    rdata_d = 32'(ptr_q);
              OFF_STATUS: rdata_d = {wrap_q, 15'h0, wr_cnt_q};
              default:    rresp_d = RESP_DECERR;
            endcase
          end
        end
      end
      RD_DATA: begin
        if (s_axil.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    arready_d = (rd_state_d == RD_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      wr_state_q   <= WR_IDLE;
      rd_state_q   <= RD_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      shadow_q     <= '0;
      ptr_q        <= '0;
      wr_cnt_q     <= '0;
      wrap_q       <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      shadow_q     <= shadow_d;
      ptr_q        <= ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      wrap_q       <= wrap_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign bram_we        = bram_we_q;
  assign bram_addr      = bram_addr_q;
  assign bram_wdata     = bram_wdata_q;

endmodule

// File: tb/tb_flow_csr_axil_slave.sv
// Self-checking bench for flow_csr_axil_slave: directed register-map scenarios plus
// randomized traffic scored against a behavioural CSR model.
module tb_flow_csr_axil_slave;
  localparam logic [31:0] BASE = 32'h8000A000;
  localparam int          AW   = 10;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } bram_wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [103:0]  flow_key;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;

  flow_csr_axil_slave_if s_axil ();

  flow_csr_axil_slave #(.BASE_ADDR(BASE), .BRAM_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axil     (s_axil),
    .flow_key   (flow_key),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Every BRAM write pulse observed, one entry per high cycle.
  bram_wr_t we_q[$];
  always @(posedge clk) begin
    #1;
    if (bram_we === 1'b1) we_q.push_back('{addr: bram_addr, data: bram_wdata});
  end

  // Behavioural CSR model.
  int unsigned  m_ptr    = 0;
  bit           m_wrap   = 1'b0;
  int unsigned  m_cnt    = 0;
  logic [103:0] m_shadow = '0;

  function automatic void model_reset();
    m_ptr = 0; m_wrap = 1'b0; m_cnt = 0; m_shadow = '0;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [1:0] resp,
                                      output bit we, output bram_wr_t wr);
    logic [31:0] merged;
    int unsigned off;
    we = 1'b0; wr = '0; resp = DECERR;
    if (addr >= BASE && (addr - BASE) < 256) begin
      off = addr - BASE;
      case (off)
        0, 4, 8, 16, 24: resp = SLVERR;
        12: begin
          if (strb == 4'hF) begin
            resp = OKAY; we = 1'b1;
            wr.addr = m_ptr[AW-1:0]; wr.data = data;
            m_ptr = (m_ptr + 1) % (1 << AW);
            if (m_ptr == 0) m_wrap = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end else resp = SLVERR;
        end
        20: begin
          resp = OKAY;
          merged = m_ptr;
          for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
          m_ptr = merged % (1 << AW);
        end
        default: resp = DECERR;
      endcase
    end
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int unsigned off;
    data = 32'h0; resp = DECERR;
    if (addr >= BASE && (addr - BASE) < 256) begin
      off = addr - BASE;
      resp = OKAY;
      case (off)
        0:  begin m_shadow = flow_key; data = flow_key[31:0]; end
        4:  data = m_shadow[63:32];
        8:  data = m_shadow[95:64];
        12: data = 32'h0;
        16: data = {24'h0, m_shadow[103:96]};
        20: data = m_ptr;
        24: data = {m_wrap, 15'h0, m_cnt[15:0]};
        default: resp = DECERR;
      endcase
    end
  endfunction

  // Bus driver for one write; expected values come from the model.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [1:0] exp_resp,
                           output bit exp_we, output bram_wr_t exp_wr);
    int n;
    bit aw_done, w_done, aw_fire, w_fire;
    model_write(addr, data, strb, exp_resp, exp_we, exp_wr);
    @(negedge clk);
    s_axil.awaddr = addr; s_axil.awvalid = 1'b1;
    s_axil.wdata = data; s_axil.wstrb = strb; s_axil.wvalid = 1'b1;
    s_axil.bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 100) begin
      aw_fire = s_axil.awvalid && s_axil.awready;
      w_fire  = s_axil.wvalid && s_axil.wready;
      @(negedge clk);
      if (aw_fire) begin s_axil.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin s_axil.wvalid = 1'b0;  w_done = 1'b1;  end
      n++;
    end
    checks++;
    if (!(aw_done && w_done) || s_axil.bvalid !== 1'b1)
      $display("FAIL wr_handshake addr=%h: bvalid=%b aw_done=%0d w_done=%0d, required bvalid=1 one cycle after AW/W",
               addr, s_axil.bvalid, aw_done, w_done);
    else passes++;
    resp = s_axil.bresp;
    @(negedge clk);
    s_axil.bready = 1'b0; s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic [31:0] exp_data, output logic [1:0] exp_resp);
    int n;
    bit done, fire;
    model_read(addr, exp_data, exp_resp);
    @(negedge clk);
    s_axil.araddr = addr; s_axil.arvalid = 1'b1; s_axil.rready = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 100) begin
      fire = s_axil.arvalid && s_axil.arready;
      @(negedge clk);
      if (fire) begin s_axil.arvalid = 1'b0; done = 1'b1; end
      n++;
    end
    checks++;
    if (!done || s_axil.rvalid !== 1'b1)
      $display("FAIL rd_latency addr=%h: rvalid=%b done=%0d, required rvalid=1 one cycle after AR", addr, s_axil.rvalid, done);
    else passes++;
    data = s_axil.rdata; resp = s_axil.rresp;
    @(negedge clk);
    s_axil.rready = 1'b0; s_axil.arvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_axil.awready, s_axil.wready, s_axil.arready, s_axil.bvalid, s_axil.rvalid, bram_we,
         s_axil.bresp, s_axil.rresp} !== 10'b0 || s_axil.rdata !== 32'h0 || bram_addr !== '0 || bram_wdata !== 32'h0)
      $display("FAIL reset_outputs: rdy/vld=%b%b%b%b%b we=%b rdata=%h baddr=%h bwdata=%h, required all zero",
               s_axil.awready, s_axil.wready, s_axil.arready, s_axil.bvalid, s_axil.rvalid, bram_we,
               s_axil.rdata, bram_addr, bram_wdata);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_axil.awready, s_axil.wready, s_axil.arready} !== 3'b111)
      $display("FAIL reset_release_ready: aw/w/ar ready=%b, required 111",
               {s_axil.awready, s_axil.wready, s_axil.arready});
    else passes++;
  endtask

  task automatic test_key_readout();
    logic [31:0] d, ed; logic [1:0] r, er;
    logic [31:0] offs [4] = '{32'h00, 32'h04, 32'h08, 32'h10};
    logic [31:0] want [4] = '{32'hD2005006, 32'hA8010204, 32'hA80101C0, 32'h000000C0};
    flow_key = {8'hC0, 32'hA80101C0, 32'hA8010204, 32'hD2005006};
    for (int i = 0; i < 4; i++) begin
      axi_read(BASE + offs[i], d, r, ed, er);
      checks++;
      if ({r, d} !== {OKAY, want[i]})
        $display("FAIL key_readout off=%h: got resp=%b data=%h, required resp=00 data=%h", offs[i], r, d, want[i]);
      else passes++;
    end
  endtask

  task automatic test_shadow();
    logic [31:0] d, ed; logic [1:0] r, er;
    axi_read(BASE + 32'h00, d, r, ed, er);
    flow_key = '1;
    axi_read(BASE + 32'h04, d, r, ed, er);
    checks++;
    if (d !== 32'hA8010204) $display("FAIL shadow_hold: got %h, required A8010204", d);
    else passes++;
    axi_read(BASE + 32'h00, d, r, ed, er);
    checks++;
    if (d !== 32'hFFFFFFFF) $display("FAIL shadow_live_word0: got %h, required FFFFFFFF", d);
    else passes++;
    axi_read(BASE + 32'h04, d, r, ed, er);
    checks++;
    if (d !== 32'hFFFFFFFF) $display("FAIL shadow_refresh64: got %h, required FFFFFFFF", d);
    else passes++;
    axi_read(BASE + 32'h10, d, r, ed, er);
    checks++;
    if (d !== 32'h000000FF) $display("FAIL shadow_refresh128: got %h, required 000000FF", d);
    else passes++;
  endtask

  task automatic test_bram_burst();
    logic [31:0] d, ed; logic [1:0] r, er; bit ewe; bram_wr_t ewr;
    we_q.delete();
    for (int i = 0; i < 5; i++) begin
      axi_write(BASE + 32'h0C, 32'hFFFFFFFF, 4'hF, r, er, ewe, ewr);
      checks++;
      if (r !== OKAY) $display("FAIL burst_bresp[%0d]: got %b, required 00", i, r);
      else passes++;
    end
    checks++;
    if (we_q.size() != 5) $display("FAIL burst_pulses: got %0d pulses, required 5", we_q.size());
    else passes++;
    for (int i = 0; i < we_q.size() && i < 5; i++) begin
      checks++;
      if (we_q[i] !== bram_wr_t'{addr: AW'(i), data: 32'hFFFFFFFF})
        $display("FAIL burst_entry[%0d]: got addr=%h data=%h, required addr=%h data=FFFFFFFF", i, we_q[i].addr, we_q[i].data, i);
      else passes++;
    end
    axi_read(BASE + 32'h18, d, r, ed, er);
    checks++;
    if (d !== 32'h00000005) $display("FAIL burst_status: got %h, required 00000005", d);
    else passes++;
    axi_read(BASE + 32'h14, d, r, ed, er);
    checks++;
    if (d !== 32'h00000005) $display("FAIL burst_ptr: got %h, required 00000005", d);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] d, ed; logic [1:0] r, er; bit ewe; bram_wr_t ewr;
    axi_write(BASE + 32'h14, 32'h000003FF, 4'hF, r, er, ewe, ewr);
    we_q.delete();
    axi_write(BASE + 32'h0C, 32'h11111111, 4'hF, r, er, ewe, ewr);
    axi_write(BASE + 32'h0C, 32'h22222222, 4'hF, r, er, ewe, ewr);
    checks++;
    if (we_q.size() != 2 || we_q[0].addr !== 10'h3FF || we_q[1].addr !== 10'h000)
      $display("FAIL wrap_addrs: got %0d pulses first=%h second=%h, required 2 pulses 3FF then 000",
               we_q.size(), we_q.size() > 0 ? we_q[0].addr : 10'h0, we_q.size() > 1 ? we_q[1].addr : 10'h0);
    else passes++;
    axi_read(BASE + 32'h18, d, r, ed, er);
    checks++;
    if (d !== 32'h80000007) $display("FAIL wrap_status: got %h, required 80000007", d);
    else passes++;
  endtask

  task automatic test_errors();
    logic [31:0] d, ed, ptr_before; logic [1:0] r, er; bit ewe; bram_wr_t ewr;
    we_q.delete();
    axi_write(BASE + 32'h00, 32'h12345678, 4'hF, r, er, ewe, ewr);
    checks++;
    if (r !== SLVERR || we_q.size() != 0) $display("FAIL ro_write: got resp=%b pulses=%0d, required resp=10 pulses=0", r, we_q.size());
    else passes++;
    axi_read(BASE + 32'h40, d, r, ed, er);
    checks++;
    if (r !== DECERR) $display("FAIL unmapped_read: got resp=%b, required 11", r);
    else passes++;
    axi_read(BASE + 32'h14, ptr_before, r, ed, er);
    axi_write(BASE + 32'h0C, 32'hDEADBEEF, 4'h3, r, er, ewe, ewr);
    checks++;
    if (r !== SLVERR || we_q.size() != 0) $display("FAIL partial_strb: got resp=%b pulses=%0d, required resp=10 pulses=0", r, we_q.size());
    else passes++;
    axi_read(BASE + 32'h14, d, r, ed, er);
    checks++;
    if (d !== ptr_before || d !== 32'h00000001) $display("FAIL partial_strb_ptr: got %h, required 00000001", d);
    else passes++;
    axi_write(BASE + 32'h100, 32'h0, 4'hF, r, er, ewe, ewr);
    checks++;
    if (r !== DECERR) $display("FAIL out_of_window_write: got resp=%b, required 11", r);
    else passes++;
    axi_read(BASE + 32'h0C, d, r, ed, er);
    checks++;
    if ({r, d} !== {OKAY, 32'h0}) $display("FAIL wo_read: got resp=%b data=%h, required 00 / 00000000", r, d);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] er1, er2; bit ewe1, ewe2; bram_wr_t ewr1, ewr2;
    model_write(BASE + 32'h0C, 32'hA5A5A5A5, 4'hF, er1, ewe1, ewr1);
    model_write(BASE + 32'h0C, 32'h5A5A5A5A, 4'hF, er2, ewe2, ewr2);
    we_q.delete();
    @(negedge clk);
    s_axil.wdata = 32'hA5A5A5A5; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1; s_axil.bready = 1'b0;
    @(negedge clk);
    s_axil.wvalid = 1'b0;
    checks++;
    if ({s_axil.awready, s_axil.wready} !== 2'b10)
      $display("FAIL w_first_ready: aw/w ready=%b, required 10", {s_axil.awready, s_axil.wready});
    else passes++;
    @(negedge clk);
    s_axil.awaddr = BASE + 32'h0C; s_axil.awvalid = 1'b1;
    @(negedge clk);
    s_axil.awvalid = 1'b0;
    checks++;
    if (s_axil.bvalid !== 1'b1 || s_axil.bresp !== OKAY)
      $display("FAIL late_aw_bvalid: bvalid=%b bresp=%b, required 1 / 00", s_axil.bvalid, s_axil.bresp);
    else passes++;
    s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1; s_axil.wdata = 32'h5A5A5A5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({s_axil.bvalid, s_axil.awready, s_axil.wready, s_axil.bresp} !== {3'b100, OKAY})
        $display("FAIL b_hold[%0d]: bvalid/awready/wready=%b%b%b bresp=%b, required 100 / 00",
                 k, s_axil.bvalid, s_axil.awready, s_axil.wready, s_axil.bresp);
      else passes++;
    end
    checks++;
    if (we_q.size() != 1) $display("FAIL b_hold_pulses: got %0d, required 1", we_q.size());
    else passes++;
    s_axil.bready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axil.bvalid !== 1'b0) $display("FAIL b_release: bvalid=%b, required 0", s_axil.bvalid);
    else passes++;
    @(negedge clk);
    s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
    checks++;
    if (s_axil.bvalid !== 1'b1) $display("FAIL second_write_bvalid: bvalid=%b, required 1", s_axil.bvalid);
    else passes++;
    @(negedge clk);
    s_axil.bready = 1'b0;
    checks++;
    if (we_q.size() != 2 || we_q[0] !== ewr1 || we_q[1] !== ewr2)
      $display("FAIL b2b_entries: got %0d pulses, required 2 with addr %h,%h", we_q.size(), ewr1.addr, ewr2.addr);
    else passes++;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return BASE + 32'h00;
      1: return BASE + 32'h04;
      2: return BASE + 32'h08;
      3: return BASE + 32'h0C;
      4: return BASE + 32'h10;
      5: return BASE + 32'h14;
      6: return BASE + 32'h18;
      7: return BASE + 32'h1C;
      8: return BASE + 32'(4 * $urandom_range(8, 63));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] addr, data, d, ed; logic [3:0] strb; logic [1:0] r, er; bit ewe; bram_wr_t ewr;
    int kind;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) flow_key = {8'($urandom), $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 5);
      if (kind >= 4) begin
        addr = pick_addr();
        axi_read(addr, d, r, ed, er);
        checks++;
        if ({r, d} !== {er, ed})
          $display("FAIL rand_read[%0d] addr=%h: got resp=%b data=%h, required resp=%b data=%h", i, addr, r, d, er, ed);
        else passes++;
      end else begin
        if (kind <= 1) begin
          addr = BASE + 32'h0C; data = $urandom;
          strb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
        end else if (kind == 2) begin
          addr = BASE + 32'h14; data = $urandom; strb = 4'($urandom);
        end else begin
          addr = pick_addr(); data = $urandom; strb = 4'($urandom);
        end
        we_q.delete();
        axi_write(addr, data, strb, r, er, ewe, ewr);
        checks++;
        if (r !== er) $display("FAIL rand_bresp[%0d] addr=%h strb=%h: got %b, required %b", i, addr, strb, r, er);
        else passes++;
        checks++;
        if (we_q.size() != (ewe ? 1 : 0) || (ewe && we_q[0] !== ewr))
          $display("FAIL rand_bram[%0d] addr=%h: got %0d pulses, required %0d at addr=%h data=%h",
                   i, addr, we_q.size(), ewe ? 1 : 0, ewr.addr, ewr.data);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed; logic [1:0] r, er;
    we_q.delete();
    @(negedge clk);
    s_axil.araddr = BASE + 32'h14; s_axil.arvalid = 1'b1; s_axil.rready = 1'b0;
    @(negedge clk);
    s_axil.arvalid = 1'b0;
    s_axil.awaddr = BASE + 32'h0C; s_axil.awvalid = 1'b1;
    @(negedge clk);
    s_axil.awvalid = 1'b0;
    checks++;
    if (s_axil.rvalid !== 1'b1) $display("FAIL pre_reset_rvalid: rvalid=%b, required 1", s_axil.rvalid);
    else passes++;
    s_axil.wdata = 32'hCAFEF00D; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    s_axil.wvalid = 1'b0;
    checks++;
    if ({s_axil.bvalid, s_axil.rvalid, s_axil.awready, s_axil.wready, s_axil.arready, bram_we} !== 6'b0)
      $display("FAIL mid_reset_outputs: bvalid/rvalid/awready/wready/arready/we=%b, required 000000",
               {s_axil.bvalid, s_axil.rvalid, s_axil.awready, s_axil.wready, s_axil.arready, bram_we});
    else passes++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if (we_q.size() != 0) $display("FAIL mid_reset_discard: got %0d pulses, required 0", we_q.size());
    else passes++;
    axi_read(BASE + 32'h14, d, r, ed, er);
    checks++;
    if (d !== 32'h0 || d !== ed) $display("FAIL mid_reset_ptr: got %h, required 00000000", d);
    else passes++;
    axi_read(BASE + 32'h18, d, r, ed, er);
    checks++;
    if (d !== 32'h0 || d !== ed) $display("FAIL mid_reset_status: got %h, required 00000000", d);
    else passes++;
    axi_read(BASE + 32'h04, d, r, ed, er);
    checks++;
    if (d !== 32'h0 || d !== ed) $display("FAIL mid_reset_shadow: got %h, required 00000000", d);
    else passes++;
  endtask

  initial begin
    s_axil.awaddr = '0; s_axil.awvalid = 1'b0; s_axil.wdata = '0; s_axil.wstrb = '0;
    s_axil.wvalid = 1'b0; s_axil.bready = 1'b0; s_axil.araddr = '0; s_axil.arvalid = 1'b0;
    s_axil.rready = 1'b0; flow_key = '0; rst_n = 1'b0;
    test_reset();
    test_key_readout();
    test_shadow();
    test_bram_burst();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
